// File: rtl/sensor_alarm_ctrl_if.sv
// rtl/sensor_alarm_ctrl_if.sv - sensor alarm controller host/sensor signal bundle
interface sensor_alarm_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 error;
    logic [3:0]           sensors;
    logic                 ack;
    logic                 clr_count;
    logic                 alarm;
    logic [3:0]           alarm_code;
    logic [CNT_WIDTH-1:0] fault_count;
    logic                 count_sat;

    modport master (
        output error, sensors, ack, clr_count,
        input  alarm, alarm_code, fault_count, count_sat
    );

    modport slave (
        input  error, sensors, ack, clr_count,
        output alarm, alarm_code, fault_count, count_sat
    );
endinterface

// File: rtl/sensor_alarm_ctrl.sv
// rtl/sensor_alarm_ctrl.sv - debounced sensor fault alarm with latched code and event counter
module sensor_alarm_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_WIDTH = 8
) (
    input logic              clk,
    input logic              n_rst,
    sensor_alarm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, QUAL, ALARM, HOLD} state_t;

    localparam logic [7:0]           QLAST   = 8'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [7:0]           qcnt;
    logic                 alarmReg;
    logic [3:0]           alarmCode;
    logic [CNT_WIDTH-1:0] faultCount;
    logic                 countSat;

    logic                 enterAlarm;
    logic [CNT_WIDTH-1:0] countNext;

    always_comb begin
        enterAlarm = 1'b0;
        if (bus.error) begin
            if (state == IDLE && DEBOUNCE == 1)
                enterAlarm = 1'b1;
            else if (state == QUAL && qcnt == QLAST)
                enterAlarm = 1'b1;
        end
    end

    // A clear coinciding with a new alarm keeps that alarm counted.
    always_comb begin
        countNext = faultCount;
        if (bus.clr_count)
            countNext = enterAlarm ? CNT_ONE : '0;
        else if (enterAlarm && faultCount != CNT_MAX)
            countNext = faultCount + CNT_ONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            qcnt       <= 8'd0;
            alarmReg   <= 1'b0;
            alarmCode  <= 4'h0;
            faultCount <= '0;
            countSat   <= 1'b0;
        end else begin
            faultCount <= countNext;
            countSat   <= (countNext == CNT_MAX);
            if (enterAlarm) begin
                state     <= ALARM;
                qcnt      <= 8'd0;
                alarmReg  <= 1'b1;
                alarmCode <= bus.sensors;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.error) begin
                            state <= QUAL;
                            qcnt  <= 8'd1;
                        end
                    end
                    QUAL: begin
                        if (!bus.error) begin
                            state <= IDLE;
                            qcnt  <= 8'd0;
                        end else begin
                            qcnt <= qcnt + 8'd1;
                        end
                    end
                    ALARM: begin
                        if (bus.ack) begin
                            alarmReg <= 1'b0;
                            state    <= bus.error ? HOLD : IDLE;
                        end
                    end
                    HOLD: begin
                        // A fault still present at acknowledge must clear before re-arming.
                        if (!bus.error)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.alarm       = alarmReg;
    assign bus.alarm_code  = alarmCode;
    assign bus.fault_count = faultCount;
    assign bus.count_sat   = countSat;
endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb/tb_sensor_alarm_ctrl.sv - self-checking bench for sensor_alarm_ctrl
module tb_sensor_alarm_ctrl;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       error;
    logic [3:0] sensors;
    logic       ack;
    logic       clr_count;

    always #5 clk = ~clk;

    sensor_alarm_ctrl_if #(.CNT_WIDTH(8)) ifA ();
    sensor_alarm_ctrl_if #(.CNT_WIDTH(2)) ifB ();

    assign ifA.error = error;  assign ifA.sensors = sensors;
    assign ifA.ack   = ack;    assign ifA.clr_count = clr_count;
    assign ifB.error = error;  assign ifB.sensors = sensors;
    assign ifB.ack   = ack;    assign ifB.clr_count = clr_count;

    sensor_alarm_ctrl #(.DEBOUNCE(4), .CNT_WIDTH(8)) dutA (
        .clk(clk), .n_rst(n_rst), .bus(ifA.slave)
    );
    sensor_alarm_ctrl #(.DEBOUNCE(1), .CNT_WIDTH(2)) dutB (
        .clk(clk), .n_rst(n_rst), .bus(ifB.slave)
    );

    int tests = 0;
    int fails = 0;

    // Model: run length of consecutive errors, plus a "blocked" flag for a fault persisting past ack.
    int mDeb[2] = '{4, 1};
    int mMax[2] = '{255, 3};
    int mRun[2];
    int mCount[2];
    int mCode[2];
    bit mAlarm[2];
    bit mBlocked[2];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mRun[i] = 0; mCount[i] = 0; mCode[i] = 0;
            mAlarm[i] = 0; mBlocked[i] = 0;
        end
    endtask

    task automatic modelStep();
        bit inc;
        for (int i = 0; i < 2; i++) begin
            inc = 0;
            if (mAlarm[i]) begin
                if (ack) begin
                    mAlarm[i] = 0;
                    mBlocked[i] = error;
                    mRun[i] = 0;
                end
            end else if (mBlocked[i]) begin
                if (!error) mBlocked[i] = 0;
            end else begin
                mRun[i] = error ? mRun[i] + 1 : 0;
                if (mRun[i] == mDeb[i]) begin
                    mAlarm[i] = 1;
                    mCode[i] = int'(sensors);
                    mRun[i] = 0;
                    inc = 1;
                end
            end
            if (clr_count) mCount[i] = inc ? 1 : 0;
            else if (inc && mCount[i] < mMax[i]) mCount[i]++;
        end
    endtask

    task automatic compareAll();
        chk("A.alarm",       int'(ifA.alarm),       int'(mAlarm[0]));
        chk("A.alarm_code",  int'(ifA.alarm_code),  mCode[0]);
        chk("A.fault_count", int'(ifA.fault_count), mCount[0]);
        chk("A.count_sat",   int'(ifA.count_sat),   int'(mCount[0] == mMax[0]));
        chk("B.alarm",       int'(ifB.alarm),       int'(mAlarm[1]));
        chk("B.alarm_code",  int'(ifB.alarm_code),  mCode[1]);
        chk("B.fault_count", int'(ifB.fault_count), mCount[1]);
        chk("B.count_sat",   int'(ifB.count_sat),   int'(mCount[1] == mMax[1]));
    endtask

    task automatic step(input bit e, input logic [3:0] s, input bit a, input bit c);
        error = e; sensors = s; ack = a; clr_count = c;
        @(posedge clk);
        #1;
        if (!n_rst) modelReset();
        else modelStep();
        compareAll();
    endtask

    initial begin
        n_rst = 1'b0; error = 1'b0; sensors = 4'h0; ack = 1'b0; clr_count = 1'b0;
        modelReset();
        step(0, 4'h0, 0, 0);
        step(0, 4'h0, 0, 0);
        chk("reset.A.alarm", int'(ifA.alarm), 0);
        chk("reset.A.fault_count", int'(ifA.fault_count), 0);
        n_rst = 1'b1;

        // Reset asserted with A mid-qualification and B already alarmed.
        step(1, 4'h7, 0, 0);
        step(1, 4'h7, 0, 0);
        chk("preReset.B.alarm", int'(ifB.alarm), 1);
        #2 n_rst = 1'b0;
        #1 modelReset();
        compareAll();
        chk("asyncReset.A.alarm", int'(ifA.alarm), 0);
        chk("asyncReset.B.alarm", int'(ifB.alarm), 0);
        chk("asyncReset.B.fault_count", int'(ifB.fault_count), 0);
        step(0, 4'h0, 0, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 4'h0, 0, 0);
        chk("idle10.A.alarm", int'(ifA.alarm), 0);

        // Debounce: a single low sample restarts qualification.
        for (int i = 0; i < 3; i++) step(1, 4'h5, 0, 0);
        step(0, 4'h5, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4'h5, 0, 0);
        chk("deb7.A.alarm", int'(ifA.alarm), 0);
        step(1, 4'h5, 0, 0);
        chk("deb8.A.alarm", int'(ifA.alarm), 1);
        chk("deb8.A.alarm_code", int'(ifA.alarm_code), 5);
        chk("deb8.A.fault_count", int'(ifA.fault_count), 1);

        // Ack with fault cleared, then re-alarm.
        step(0, 4'h5, 1, 0);
        chk("ackClr.A.alarm", int'(ifA.alarm), 0);
        chk("ackClr.A.alarm_code", int'(ifA.alarm_code), 5);
        for (int i = 0; i < 4; i++) step(1, 4'hA, 0, 0);
        chk("realarm.A.fault_count", int'(ifA.fault_count), 2);
        chk("realarm.A.alarm_code", int'(ifA.alarm_code), 10);

        // Ack while the fault persists: no re-alarm until it clears.
        step(1, 4'hA, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 4'hA, 0, 0);
        chk("hold.A.alarm", int'(ifA.alarm), 0);
        chk("hold.B.alarm", int'(ifB.alarm), 0);
        step(0, 4'h3, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 4'h3, 0, 0);
        chk("holdExit.A.alarm", int'(ifA.alarm), 1);
        chk("holdExit.A.fault_count", int'(ifA.fault_count), 3);
        chk("sat3.B.fault_count", int'(ifB.fault_count), 3);
        chk("sat3.B.count_sat", int'(ifB.count_sat), 1);

        // Fourth B alarm leaves its saturated count unchanged.
        step(0, 4'h0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 4'h6, 0, 0);
        chk("sat4.B.fault_count", int'(ifB.fault_count), 3);
        chk("sat4.A.fault_count", int'(ifA.fault_count), 4);

        // Clear coinciding with B's fifth alarm entry.
        step(0, 4'h0, 1, 0);
        step(1, 4'hC, 0, 1);
        chk("clrInc.B.fault_count", int'(ifB.fault_count), 1);
        chk("clrInc.B.count_sat", int'(ifB.count_sat), 0);
        chk("clrInc.A.fault_count", int'(ifA.fault_count), 0);
        for (int i = 0; i < 3; i++) step(1, 4'hC, 0, 0);
        chk("clrAfter.A.fault_count", int'(ifA.fault_count), 1);

        // Ack held high through IDLE and QUAL is ignored; drops alarm the edge after entry.
        step(0, 4'h0, 1, 0);
        step(0, 4'h0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 4'h9, 1, 0);
        chk("ackQual.A.alarm", int'(ifA.alarm), 0);
        step(1, 4'h9, 1, 0);
        chk("ackEntry.A.alarm", int'(ifA.alarm), 1);
        chk("ackEntry.A.alarm_code", int'(ifA.alarm_code), 9);
        step(1, 4'h9, 1, 0);
        chk("ackNext.A.alarm", int'(ifA.alarm), 0);
        chk("ackNext.A.fault_count", int'(ifA.fault_count), 2);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
